ir_nec_transmitter: RTL

IR_NEC_TRANSMITTER -- requirements
Module: ir_nec_transmitter

---
 rtl/ir_nec_transmitter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter -- NEC infrared frame transmitter.
//
// Sends one NEC frame per accepted request. The frame is a 9 ms leader mark,
// a 4.5 ms leader space, 32 pulse-distance data bits (LSB first, word
// {~cmd, cmd, ~addr, addr}), a stop mark and a 16-unit inter-frame gap.
// Because the payload always holds 16 ones and 16 zeros, every frame
// (gap included) lasts exactly 137 units.
//
// Parameters:
//   UNIT_CYCLES  - clk_50 cycles per 562.5 us NEC unit
//   CARRIER_HALF - clk_50 cycles per carrier half-period
//
// Ports:
//   clk_50  in   system clock
//   reset   in   synchronous active-high reset (wins over start)
//   start   in   frame request, accepted only while busy = 0
//   addr    in   [7:0] NEC address byte
//   cmd     in   [7:0] NEC command byte
//   busy    out  frame or inter-frame gap in progress
//   done    out  one-cycle pulse in the first idle cycle after a frame
//   ir_env  out  unmodulated mark envelope (1 = mark)
//   ir_tx   out  emitter drive
//
// Build option: IR_CARRIER_EN -- when defined, ir_tx is the envelope gated
// by the 38 kHz carrier; when undefined, ir_tx equals the envelope so it can
// be wired straight into an IR receive path.
module ir_nec_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_tx
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } state_t;

  state_t        state;
  logic [UW-1:0] unit_cnt;
  logic [4:0]    seg_cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   shift;
  logic [4:0]    seg_last;
  logic          seg_end;
  logic          env_nxt;

  // Last unit index of the current segment; a data space is 3 units for a 1.
  always_comb begin
    seg_last = 5'd0;
    case (state)
      LEAD_MARK:  seg_last = 5'd15;
      LEAD_SPACE: seg_last = 5'd7;
      BIT_SPACE:  seg_last = shift[0] ? 5'd2 : 5'd0;
      GAP:        seg_last = 5'd15;
      default:    seg_last = 5'd0;
    endcase
  end

  assign seg_end = (unit_cnt == UNIT_LAST) && (seg_cnt == seg_last);

  // Envelope value for the next cycle; lets ir_env and ir_tx be registered
  // without lagging the state by a cycle.
  always_comb begin
    env_nxt = 1'b0;
    case (state)
      IDLE:       env_nxt = start;
      LEAD_MARK:  env_nxt = ~seg_end;
      LEAD_SPACE: env_nxt = seg_end;
      BIT_MARK:   env_nxt = ~seg_end;
      BIT_SPACE:  env_nxt = seg_end;   // both successors are marks
      STOP_MARK:  env_nxt = ~seg_end;
      GAP:        env_nxt = 1'b0;
      default:    env_nxt = 1'b0;
    endcase
  end

  // Frame sequencer: state, unit/segment/bit counters, shift word, flags.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state    <= IDLE;
      unit_cnt <= '0;
      seg_cnt  <= 5'd0;
      bit_idx  <= 5'd0;
      shift    <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ir_env   <= 1'b0;
    end else begin
      done   <= 1'b0;
      ir_env <= env_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEAD_MARK;
            busy     <= 1'b1;
            shift    <= {~cmd, cmd, ~addr, addr};
            unit_cnt <= '0;
            seg_cnt  <= 5'd0;
            bit_idx  <= 5'd0;
          end
        end
        default: begin
          if (unit_cnt != UNIT_LAST) begin
            unit_cnt <= unit_cnt + UW'(1);
          end else begin
            unit_cnt <= '0;
            if (!seg_end) begin
              seg_cnt <= seg_cnt + 5'd1;
            end else begin
              seg_cnt <= 5'd0;
              case (state)
                LEAD_MARK:  state <= LEAD_SPACE;
                LEAD_SPACE: state <= BIT_MARK;
                BIT_MARK:   state <= BIT_SPACE;
                BIT_SPACE: begin
                  shift   <= {1'b0, shift[31:1]};
                  bit_idx <= bit_idx + 5'd1;
                  state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                end
                STOP_MARK:  state <= GAP;
                GAP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
                default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

`ifdef IR_CARRIER_EN
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] car_cnt;
  logic          carrier;

  // Carrier phase restarts high on every mark entry and toggles every
  // CARRIER_HALF cycles while the mark lasts; ir_tx is the gated result.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      car_cnt <= '0;
      carrier <= 1'b0;
      ir_tx   <= 1'b0;
    end else if (env_nxt && !ir_env) begin
      car_cnt <= '0;
      carrier <= 1'b1;
      ir_tx   <= 1'b1;
    end else if (env_nxt) begin
      if (car_cnt == CAR_LAST) begin
        car_cnt <= '0;
        carrier <= ~carrier;
        ir_tx   <= ~carrier;
      end else begin
        car_cnt <= car_cnt + CW'(1);
        ir_tx   <= carrier;
      end
    end else begin
      car_cnt <= '0;
      carrier <= 1'b0;
      ir_tx   <= 1'b0;
    end
  end
`else
  // Unmodulated drive: ir_tx mirrors the envelope for wired loopback.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      ir_tx <= 1'b0;
    end else begin
      ir_tx <= env_nxt;
    end
  end
`endif

endmodule
